stream_byte_assembler: RTL

- Assembles a byte stream (e.g. from the host UART/FIFO receiver) into full source words of SRC_WIDTH bits: {opcode, NET_NUM_INP charges}.
- Sits directly upstream of network_source; out_valid/out_ready/out_data connect to its src_valid/src_ready/src.
- Double-buffered: collects the next word while the previous one waits for downstream.
- Optional inactivity timeout discards stale partial words so the host can resynchronise.

---
 rtl/stream_byte_assembler.sv | 111 +++++++++++
 1 files changed

// File: rtl/stream_byte_assembler.sv
// rtl/stream_byte_assembler.sv - packs a byte stream into double-buffered source words with optional stale-word timeout
module stream_byte_assembler #(
  parameter int SRC_WIDTH      = 17,
  parameter int BYTE_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BYTE_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SRC_WIDTH-1:0]  out_data,
  output logic                  drop
);

  localparam int BYTES = (SRC_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

  logic [CNT_W-1:0]     count_q;
  logic                 accept;
  logic                 final_byte;
  logic                 timeout_fire;
  logic [SRC_WIDTH-1:0] word;

  // Only the closing byte of a word needs the output register, so only it can stall.
  assign in_ready   = (count_q != LAST) || !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign final_byte = accept && (count_q == LAST);

  generate
    if (BYTES > 1) begin : g_multi
      // Only the low SRC_WIDTH-BYTE_WIDTH bits of the earlier bytes can reach the
      // word, so the pad bits of byte0 are simply shifted out and never stored.
      localparam int ASM_W = SRC_WIDTH - BYTE_WIDTH;
      logic [ASM_W-1:0] asm_q;

      // Shift each non-final byte into the assembly register, oldest byte on top.
      always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
          asm_q <= '0;
        end else if (accept && !final_byte) begin
          asm_q <= ASM_W'({asm_q, in_data});
        end
      end

      assign word = {asm_q, in_data};
    end else begin : g_single
      assign word = SRC_WIDTH'(in_data);
    end
  endgenerate

  // Byte position within the current word; a timeout restarts at byte0.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      count_q <= '0;
    end else if (accept) begin
      count_q <= (count_q == LAST) ? '0 : count_q + CNT_W'(1);
    end else if (timeout_fire) begin
      count_q <= '0;
    end
  end

  // Output register: load on the final byte (retiring any old word the same edge), else drain.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (final_byte) begin
      out_valid <= 1'b1;
      out_data  <= word;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
      logic [IDLE_W-1:0] idle_q;
      logic              drop_q;

      // Fires on the edge that would complete the last allowed idle cycle; a byte on that edge wins.
      assign timeout_fire = !accept && (count_q != '0) &&
                            (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

      // Count idle cycles while a partial word is pending and flag a discard for one cycle.
      always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
          idle_q <= '0;
          drop_q <= 1'b0;
        end else begin
          drop_q <= timeout_fire;
          if (accept || (count_q == '0) || timeout_fire) begin
            idle_q <= '0;
          end else begin
            idle_q <= idle_q + IDLE_W'(1);
          end
        end
      end

      assign drop = drop_q;
    end else begin : g_no_timeout
      assign timeout_fire = 1'b0;
      assign drop         = 1'b0;
    end
  endgenerate

endmodule
